cr_xp10_decomp_ob_rx: RTL and testbench
=======================================

CR_XP10_DECOMP_OB_RX -- requirements
Module: cr_xp10_decomp_ob_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of entries in the receive buffer (power of two, minimum 4).
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port ob_in_tvalid, input, 1 bit: stream word valid.
REQ-005 SHALL have port ob_in_tdata, input, 64 bits: stream word.
REQ-006 SHALL have port ob_in_tlast, input, 1 bit: last word of the TLV.
REQ-007 SHALL have port ob_in_tuser, input, 8 bits: bit0 is sot, bit1 is eot, the remaining bits are passed through.
REQ-008 SHALL have port ob_in_tready, output, 1 bit: registered backpressure.
REQ-009 SHALL have ports tlv_valid (output, 1), tlv_data (output, 64), tlv_sot (output, 1), tlv_eot (output, 1) and tlv_type (output, 8): the parsed word to the consumer.
REQ-010 SHALL have port tlv_rd, input, 1 bit: consumer pop, legal only while tlv_valid is high.
REQ-011 SHALL have ports err_valid (output, 1, one-cycle pulse) and err_code (output, 2 bits): framing error report.

Function
REQ-012 SHALL accept a word when ob_in_tvalid and ob_in_tready are both high; it SHALL push the word, its tlast and its tuser into the FIFO.
REQ-013 SHALL drive ob_in_tready from a register, set next cycle when the next-cycle occupancy is at most FIFO_DEPTH-2; no word is lost while tready deasserts.
REQ-014 SHALL decode the header word with type = tdata[7:0] and len = tdata[23:8], where len is the number of payload words following the header.
REQ-015 SHALL implement an FSM with states HDR, PAY and DRAIN; the reset state is HDR.
REQ-016 SHALL handle a word accepted in HDR as follows.
- Requires sot=1.
- Captures type and loads the payload counter with len.
- Goes to PAY if len>0 and tlast=0.
- Stays in HDR if len=0 and tlast=1.
REQ-017 SHALL, in PAY, decrement the counter on each accepted word; the word where the counter reaches 1 must carry tlast=1 and eot=1, then the FSM returns to HDR.
REQ-018 SHALL pulse err_valid for one cycle on a framing error, with these codes:
- 1: no sot in HDR.
- 2: tlast before the counter expires.
- 3: counter expires without tlast.
REQ-019 SHALL, on codes 1 and 3, enter DRAIN and discard words without pushing them until the word with tlast=1, then go to HDR; code 2 returns directly to HDR.
REQ-020 SHALL push words discarded in DRAIN to no output, while ob_in_tready keeps following occupancy.
REQ-021 SHALL drive tlv_type equal to the captured type for every word of the TLV, including the header.
REQ-022 SHALL present the FIFO head on tlv_* (first-word fall-through); latency from acceptance to tlv_valid is 1 cycle.
REQ-023 SHALL allow a push and a pop in the same cycle with occupancy unchanged, including when the FIFO is full.
REQ-024 SHALL treat tlv_rd while tlv_valid is low as ignored.
REQ-025 SHALL wrap the FIFO pointers modulo FIFO_DEPTH and use an occupancy counter of width log2(FIFO_DEPTH)+1.

Reset
REQ-026 SHALL, while rst is high, clear these outputs to 0: ob_in_tready, tlv_valid, tlv_data, tlv_sot, tlv_eot, tlv_type, err_valid and err_code.
REQ-027 SHALL also clear the FIFO and its pointers, set the counter to 0 and set the FSM to HDR.
REQ-028 SHALL, when rst is asserted mid-TLV, abandon that TLV without generating an error; ob_in_tready rises on the first clk edge after release.

Configuration
REQ-029 SHALL, with CR_XP10_DECOMP_OB_RX_STATS_EN defined, add outputs stat_tlv_cnt (32 bits, complete TLVs popped with eot) and stat_err_cnt (16 bits, err_valid pulses).
- Both counters saturate at their maximum value.
- Both counters reset to 0.
REQ-030 SHALL, without the macro, have neither these ports nor these counters.

Structure
REQ-031 SHALL place the err_code enumeration (NONE, NO_SOT, EARLY_LAST, MISSING_LAST), the header field offsets and the FSM state typedef in cr_xp10_decompPKG.
REQ-032 SHALL implement the buffer as the sub-module cr_xp10_decomp_ob_rx_fifo.

Verification
REQ-033 SHALL have a bench cover a clean TLV: header type=0x05, len=3, followed by 3 payload words with the last one carrying tlast and eot.
- Response: 4 tlv words in order with tlv_type=0x05.
- sot only on the first word, eot only on the last.
- No err_valid.
REQ-034 SHALL have a bench cover an early tlast: header with len=4, then tlast on the 2nd payload word.
- Response: err_valid with code 2.
- The FSM is in HDR on the next cycle.
REQ-035 SHALL have a bench cover a missing sot: a word with sot=0 in HDR, followed by 2 further words, the last of which has tlast.
- Response: err code 1.
- All 3 words are discarded; tlv_valid stays 0.
REQ-036 SHALL have a bench cover backpressure: tlv_rd held low while 10 words are sent.
- ob_in_tready drops after 3 accepted words.
- No loss or duplication once tlv_rd=1.
REQ-037 SHALL have a bench cover simultaneous push and pop at full with a continuous stream, checking that occupancy stays constant.
REQ-038 SHALL have a bench cover reset mid-payload: rst pulsed after the 2nd of 5 payload words.
- Response: outputs are 0 during reset.
- The next header is parsed cleanly.

Source files
------------

// File: rtl/cr_xp10_decomp_ob_rx_pkg.sv
// Shared types for the XP10 decompressor outbound TLV receiver:
// framing error codes, header field offsets, FSM states and FIFO entry layout.
package cr_xp10_decompPKG;

    localparam int OB_DATA_W     = 64;
    localparam int OB_USER_W     = 8;

    // Header word layout: type in the low byte, payload word count above it
    localparam int HDR_TYPE_LSB  = 0;
    localparam int HDR_TYPE_W    = 8;
    localparam int HDR_LEN_LSB   = 8;
    localparam int HDR_LEN_W     = 16;

    // tuser sideband bits
    localparam int TUSER_SOT_BIT = 0;
    localparam int TUSER_EOT_BIT = 1;

    typedef enum logic [1:0] {
        NONE         = 2'd0,
        NO_SOT       = 2'd1,
        EARLY_LAST   = 2'd2,
        MISSING_LAST = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {
        HDR   = 2'd0,
        PAY   = 2'd1,
        DRAIN = 2'd2
    } ob_rx_state_e;

    // One buffered stream word plus the TLV type it belongs to
    typedef struct packed {
        logic [HDR_TYPE_W-1:0] tlv_type;
        logic [OB_USER_W-1:0]  tuser;
        logic                  tlast;
        logic [OB_DATA_W-1:0]  data;
    } ob_rx_entry_t;

    function automatic logic [HDR_TYPE_W-1:0] hdr_type(input logic [OB_DATA_W-1:0] w);
        return w[HDR_TYPE_LSB +: HDR_TYPE_W];
    endfunction

    function automatic logic [HDR_LEN_W-1:0] hdr_len(input logic [OB_DATA_W-1:0] w);
        return w[HDR_LEN_LSB +: HDR_LEN_W];
    endfunction

endpackage

// File: rtl/cr_xp10_decomp_ob_rx_fifo.sv
// First-word fall-through receive buffer. The head entry is visible the
// cycle after it is written; wr_ready is registered and deasserts early
// enough that a word already in flight always finds room.
module cr_xp10_decomp_ob_rx_fifo
    import cr_xp10_decompPKG::*;
#(
    parameter int FIFO_DEPTH = 4
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  ob_rx_entry_t wr_data,
    input  logic         rd_en,
    output ob_rx_entry_t rd_data,
    output logic         rd_valid,
    output logic         wr_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] READY_MAX = CW'(FIFO_DEPTH - 2);

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          wr_ready_reg;
    logic          push;
    logic          pop;
    ob_rx_entry_t  mem [FIFO_DEPTH];

    // A pop frees the head slot in the same cycle, so push+pop at full is legal
    assign pop  = rd_en && (count_reg != '0);
    assign push = wr_en && ((count_reg != FULL_CNT) || pop);

    // Next-cycle occupancy
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Pointers, occupancy and registered ready (power-of-two depth wraps naturally)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            wr_ready_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg    <= count_next;
            wr_ready_reg <= (count_next <= READY_MAX);
        end
    end

    // Storage: one cleared register per slot
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            ob_rx_entry_t entry_reg;

            // Capture the incoming word when this slot is the write target
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    entry_reg <= '0;
                else if (push && (wr_ptr_reg == AW'(gi)))
                    entry_reg <= wr_data;
            end

            assign mem[gi] = entry_reg;
        end
    endgenerate

    assign rd_data  = mem[rd_ptr_reg];
    assign rd_valid = (count_reg != '0);
    assign wr_ready = wr_ready_reg;

endmodule

// File: rtl/cr_xp10_decomp_ob_rx.sv
// Outbound TLV receiver: parses header/payload framing of a 64-bit stream,
// tags every word with its TLV type, reports framing errors and buffers the
// accepted words for the consumer.
// Optional statistics counters: define CR_XP10_DECOMP_OB_RX_STATS_EN.
module cr_xp10_decomp_ob_rx
    import cr_xp10_decompPKG::*;
#(
    parameter int FIFO_DEPTH = 4
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ob_in_tvalid,
    input  logic [63:0] ob_in_tdata,
    input  logic        ob_in_tlast,
    input  logic [7:0]  ob_in_tuser,
    output logic        ob_in_tready,
    output logic        tlv_valid,
    output logic [63:0] tlv_data,
    output logic        tlv_sot,
    output logic        tlv_eot,
    output logic [7:0]  tlv_type,
    input  logic        tlv_rd,
    output logic        err_valid,
    output logic [1:0]  err_code
`ifdef CR_XP10_DECOMP_OB_RX_STATS_EN
    ,
    output logic [31:0] stat_tlv_cnt,
    output logic [15:0] stat_err_cnt
`endif
);

    ob_rx_state_e state_reg, state_next;
    logic [HDR_LEN_W-1:0]  cnt_reg, cnt_next;
    logic [HDR_TYPE_W-1:0] type_reg, type_next;
    logic                  err_valid_reg, err_valid_next;
    err_code_e             err_code_reg, err_code_next;

    logic         accept;
    logic         sot;
    logic         push;
    logic         fifo_ready;
    logic         head_valid;
    ob_rx_entry_t push_entry;
    ob_rx_entry_t head;
    logic         unused_head_bits;

    assign accept = ob_in_tvalid && fifo_ready;
    assign sot    = ob_in_tuser[TUSER_SOT_BIT];

    // Framing FSM: decides push/discard, tracks the payload count, flags errors
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        type_next      = type_reg;
        err_valid_next = 1'b0;
        err_code_next  = NONE;
        push           = 1'b0;
        push_entry     = '{tlv_type: type_reg, tuser: ob_in_tuser,
                           tlast: ob_in_tlast, data: ob_in_tdata};
        if (accept) begin
            case (state_reg)
                HDR: begin
                    if (!sot) begin
                        err_valid_next = 1'b1;
                        err_code_next  = NO_SOT;
                        if (!ob_in_tlast) state_next = DRAIN;
                    end else begin
                        push                = 1'b1;
                        push_entry.tlv_type = hdr_type(ob_in_tdata);
                        type_next           = hdr_type(ob_in_tdata);
                        if (hdr_len(ob_in_tdata) != '0 && !ob_in_tlast) begin
                            cnt_next   = hdr_len(ob_in_tdata);
                            state_next = PAY;
                        end else if (hdr_len(ob_in_tdata) != '0) begin
                            err_valid_next = 1'b1;
                            err_code_next  = EARLY_LAST;
                        end else if (!ob_in_tlast) begin
                            err_valid_next = 1'b1;
                            err_code_next  = MISSING_LAST;
                            state_next     = DRAIN;
                        end
                    end
                end
                PAY: begin
                    push = 1'b1;
                    if (cnt_reg == HDR_LEN_W'(1)) begin
                        cnt_next = '0;
                        if (ob_in_tlast) begin
                            state_next = HDR;
                        end else begin
                            err_valid_next = 1'b1;
                            err_code_next  = MISSING_LAST;
                            state_next     = DRAIN;
                        end
                    end else if (ob_in_tlast) begin
                        err_valid_next = 1'b1;
                        err_code_next  = EARLY_LAST;
                        cnt_next       = '0;
                        state_next     = HDR;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                DRAIN: begin
                    if (ob_in_tlast) state_next = HDR;
                end
                default: state_next = HDR;
            endcase
        end
    end

    // FSM, counter, captured type and error pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= HDR;
            cnt_reg       <= '0;
            type_reg      <= '0;
            err_valid_reg <= 1'b0;
            err_code_reg  <= NONE;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            type_reg      <= type_next;
            err_valid_reg <= err_valid_next;
            err_code_reg  <= err_code_next;
        end
    end

    cr_xp10_decomp_ob_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (push),
        .wr_data  (push_entry),
        .rd_en    (tlv_rd),
        .rd_data  (head),
        .rd_valid (head_valid),
        .wr_ready (fifo_ready)
    );

    assign ob_in_tready = fifo_ready;
    assign tlv_valid    = head_valid;
    assign tlv_data     = head.data;
    assign tlv_sot      = head.tuser[TUSER_SOT_BIT];
    assign tlv_eot      = head.tuser[TUSER_EOT_BIT];
    assign tlv_type     = head.tlv_type;
    assign err_valid    = err_valid_reg;
    assign err_code     = err_code_reg;

    // tlast and passthrough tuser bits travel with the word but have no consumer port
    assign unused_head_bits = ^{head.tlast, head.tuser[7:2]};

`ifdef CR_XP10_DECOMP_OB_RX_STATS_EN
    logic [31:0] stat_tlv_cnt_reg;
    logic [15:0] stat_err_cnt_reg;

    // Saturating counts of completed TLVs popped and of error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_tlv_cnt_reg <= '0;
            stat_err_cnt_reg <= '0;
        end else begin
            if (head_valid && tlv_rd && head.tuser[TUSER_EOT_BIT] && (stat_tlv_cnt_reg != '1))
                stat_tlv_cnt_reg <= stat_tlv_cnt_reg + 1'b1;
            if (err_valid_reg && (stat_err_cnt_reg != '1))
                stat_err_cnt_reg <= stat_err_cnt_reg + 1'b1;
        end
    end

    assign stat_tlv_cnt = stat_tlv_cnt_reg;
    assign stat_err_cnt = stat_err_cnt_reg;
`endif

endmodule

// File: tb/tb_cr_xp10_decomp_ob_rx.sv
// Scoreboard bench for cr_xp10_decomp_ob_rx: expected tlv words and error
// codes are queued as stimulus is issued; monitors pop and compare.
module tb_cr_xp10_decomp_ob_rx;
    import cr_xp10_decompPKG::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ob_in_tvalid = 1'b0;
    logic [63:0] ob_in_tdata = '0;
    logic        ob_in_tlast = 1'b0;
    logic [7:0]  ob_in_tuser = '0;
    logic        ob_in_tready;
    logic        tlv_valid;
    logic [63:0] tlv_data;
    logic        tlv_sot;
    logic        tlv_eot;
    logic [7:0]  tlv_type;
    logic        tlv_rd = 1'b0;
    logic        err_valid;
    logic [1:0]  err_code;

    int n_vec  = 0;
    int n_miss = 0;
    int acc_cnt = 0;
    int base_cnt;

    logic [73:0] exp_q[$];
    logic [1:0]  err_q[$];
    logic [73:0] got_word, exp_word;
    logic [1:0]  exp_code;

    always #5 clk = ~clk;

    cr_xp10_decomp_ob_rx #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .ob_in_tvalid (ob_in_tvalid),
        .ob_in_tdata  (ob_in_tdata),
        .ob_in_tlast  (ob_in_tlast),
        .ob_in_tuser  (ob_in_tuser),
        .ob_in_tready (ob_in_tready),
        .tlv_valid    (tlv_valid),
        .tlv_data     (tlv_data),
        .tlv_sot      (tlv_sot),
        .tlv_eot      (tlv_eot),
        .tlv_type     (tlv_type),
        .tlv_rd       (tlv_rd),
        .err_valid    (err_valid),
        .err_code     (err_code)
    );

    // Count accepted input words
    always @(posedge clk)
        if (!rst && ob_in_tvalid && ob_in_tready) acc_cnt <= acc_cnt + 1;

    // Monitor: compare every popped word and every error pulse against the queues
    always @(negedge clk) begin
        if (!rst && tlv_valid && tlv_rd) begin
            got_word = {tlv_data, tlv_sot, tlv_eot, tlv_type};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL tlv_word: got data=%h sot=%b eot=%b type=%h, required no word", tlv_data, tlv_sot, tlv_eot, tlv_type);
            end else begin
                exp_word = exp_q.pop_front();
                if (got_word !== exp_word) begin
                    n_miss++;
                    $display("FAIL tlv_word: got %h, required %h", got_word, exp_word);
                end else begin
                    $display("tlv word data=%h sot=%b eot=%b type=%h", tlv_data, tlv_sot, tlv_eot, tlv_type);
                end
            end
        end
        if (!rst && err_valid) begin
            n_vec++;
            if (err_q.size() == 0) begin
                n_miss++;
                $display("FAIL err_pulse: got code %0d, required no error", err_code);
            end else begin
                exp_code = err_q.pop_front();
                if (err_code !== exp_code) begin
                    n_miss++;
                    $display("FAIL err_code: got %0d, required %0d", err_code, exp_code);
                end else begin
                    $display("err pulse code=%0d", err_code);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_vec++;
        if (got !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [7:0] ty, input logic [15:0] len, input logic [39:0] upper);
        return {upper, len, ty};
    endfunction

    // Present one word and hold it until accepted; optionally queue its expected tlv word
    task automatic send(input logic [63:0] d, input logic s, input logic e, input logic last,
                        input bit exp_push, input logic [7:0] ty);
        bit done = 0;
        if (exp_push) exp_q.push_back({d, s, e, ty});
        ob_in_tvalid = 1'b1;
        ob_in_tdata  = d;
        ob_in_tuser  = {6'b101101, e, s};
        ob_in_tlast  = last;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (ob_in_tready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        if (!done) begin
            n_vec++;
            n_miss++;
            $display("FAIL send_timeout: got no acceptance of %h, required acceptance within 200 cycles", d);
        end
    endtask

    task automatic idle_drain();
        ob_in_tvalid = 1'b0;
        ob_in_tlast  = 1'b0;
        ob_in_tuser  = '0;
        for (int i = 0; i < 100 && tlv_valid; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tready",    64'(ob_in_tready), 64'd0);
        check("rst_tlv_valid", 64'(tlv_valid),    64'd0);
        check("rst_tlv_data",  tlv_data,          64'd0);
        check("rst_tlv_flags", 64'({tlv_sot, tlv_eot, tlv_type}), 64'd0);
        check("rst_err",       64'({err_valid, err_code}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("tready_after_release", 64'(ob_in_tready), 64'd1);
        tlv_rd = 1'b1;

        // Clean TLV: type 0x05, three payload words
        send(hdr(8'h05, 16'd3, 40'h1122334455), 1, 0, 0, 1, 8'h05);
        check("first_word_latency", 64'(tlv_valid), 64'd1);
        send(64'hA000_0000_0000_0001, 0, 0, 0, 1, 8'h05);
        send(64'hA000_0000_0000_0002, 0, 0, 0, 1, 8'h05);
        send(64'hA000_0000_0000_0003, 0, 1, 1, 1, 8'h05);
        idle_drain();

        // Early tlast: len 4, tlast on 2nd payload word -> code 2, back to HDR
        send(hdr(8'h22, 16'd4, 40'h0), 1, 0, 0, 1, 8'h22);
        send(64'hB000_0000_0000_0001, 0, 0, 0, 1, 8'h22);
        err_q.push_back(2'd2);
        send(64'hB000_0000_0000_0002, 0, 1, 1, 1, 8'h22);
        check("state_after_early_last", 64'(dut.state_reg), 64'(HDR));
        send(hdr(8'h33, 16'd0, 40'hCAFE), 1, 1, 1, 1, 8'h33);
        idle_drain();

        // Missing sot: three words discarded, code 1
        err_q.push_back(2'd1);
        send(64'hBAD0_0000_0000_0001, 0, 0, 0, 0, 8'h00);
        check("nosot_valid_w1", 64'(tlv_valid), 64'd0);
        send(64'hBAD0_0000_0000_0002, 0, 0, 0, 0, 8'h00);
        check("nosot_valid_w2", 64'(tlv_valid), 64'd0);
        send(64'hBAD0_0000_0000_0003, 0, 1, 1, 0, 8'h00);
        check("nosot_valid_w3", 64'(tlv_valid), 64'd0);
        check("state_after_drain", 64'(dut.state_reg), 64'(HDR));
        send(hdr(8'h3C, 16'd1, 40'h0), 1, 0, 0, 1, 8'h3C);
        send(64'hC000_0000_0000_0001, 0, 1, 1, 1, 8'h3C);
        idle_drain();

        // Backpressure: consumer stalled while a 10-word TLV is offered
        tlv_rd   = 1'b0;
        base_cnt = acc_cnt;
        fork
            begin
                send(hdr(8'h66, 16'd9, 40'h0), 1, 0, 0, 1, 8'h66);
                for (int k = 1; k <= 9; k++)
                    send(64'h6600_0000_0000_0000 | 64'(k), 0, (k == 9), (k == 9), 1, 8'h66);
            end
            begin
                repeat (12) @(posedge clk);
                #1;
                check("bp_accepted", 64'(acc_cnt - base_cnt), 64'd3);
                check("bp_tready_low", 64'(ob_in_tready), 64'd0);
                check("bp_occupancy", 64'(dut.u_fifo.count_reg), 64'd3);
                tlv_rd = 1'b1;
            end
        join
        idle_drain();

        // Continuous stream at the deepest occupancy: push and pop every cycle
        tlv_rd = 1'b0;
        fork
            begin
                send(hdr(8'h77, 16'd15, 40'h0), 1, 0, 0, 1, 8'h77);
                for (int k = 1; k <= 15; k++)
                    send(64'h7700_0000_0000_0000 | 64'(k), 0, (k == 15), (k == 15), 1, 8'h77);
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                check("stream_fill", 64'(dut.u_fifo.count_reg), 64'd3);
                tlv_rd = 1'b1;
                @(posedge clk);
                #1;
                for (int c = 0; c < 8; c++) begin
                    @(negedge clk);
                    check("stream_occupancy", 64'(dut.u_fifo.count_reg), 64'd2);
                    check("stream_tready", 64'(ob_in_tready), 64'd1);
                end
            end
        join
        idle_drain();

        // Reset mid-payload: abandoned words are never expected, no error
        tlv_rd = 1'b0;
        send(hdr(8'h44, 16'd5, 40'h0), 1, 0, 0, 0, 8'h44);
        send(64'hD000_0000_0000_0001, 0, 0, 0, 0, 8'h44);
        send(64'hD000_0000_0000_0002, 0, 0, 0, 0, 8'h44);
        ob_in_tvalid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_tready",    64'(ob_in_tready), 64'd0);
        check("midrst_tlv_valid", 64'(tlv_valid),    64'd0);
        check("midrst_tlv_data",  tlv_data,          64'd0);
        check("midrst_tlv_flags", 64'({tlv_sot, tlv_eot, tlv_type}), 64'd0);
        check("midrst_err",       64'({err_valid, err_code}), 64'd0);
        repeat (2) @(negedge clk);
        check("midrst_hold_valid", 64'(tlv_valid), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_tready_rise", 64'(ob_in_tready), 64'd1);
        check("midrst_state", 64'(dut.state_reg), 64'(HDR));
        tlv_rd = 1'b1;
        send(hdr(8'h55, 16'd1, 40'hBEEF), 1, 0, 0, 1, 8'h55);
        send(64'hE000_0000_0000_0001, 0, 1, 1, 1, 8'h55);
        idle_drain();

        // Everything expected must have been seen
        repeat (5) @(posedge clk);
        #1;
        check("exp_words_left", 64'(exp_q.size()), 64'd0);
        check("exp_errs_left",  64'(err_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
